// File: rtl/ahb_img_fetch_if.sv
// Bus bundle for the image fetcher: AHB-Lite read master signals plus the outgoing pixel stream.
interface ahb_img_fetch_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, pix_data, pix_valid,
        input  HREADY, HRDATA, pix_ready
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, pix_data, pix_valid,
        output HREADY, HRDATA, pix_ready
    );
endinterface

// File: rtl/ahb_img_fetch.sv
// AHB-Lite single-word read master: fetches a frame into a word FIFO and streams it out as bytes.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_RUN   | issuing address phases (gated by FIFO room)
//   ST_DRAIN | all addresses issued; finishing data phase and emptying FIFO
module ahb_img_fetch #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    ahb_img_fetch_if.master  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    logic [1:0]       state;
    logic [29:0]      addr_q;
    logic [LEN_W-1:0] words_left;
    logic             outstanding;
    logic             seq_q;
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [1:0]       byte_idx;
    logic [AW+1:0]    fill;
    logic             issue, accept, push, pop, pix_fire, last_byte;
    logic [31:0]      head_word;
    logic             base_lsb_unused;

    assign base_lsb_unused = ^base_addr[1:0];

    // An in-flight data phase already owns a FIFO slot, so it counts against room.
    assign fill      = {1'b0, count} + (AW+2)'(outstanding);
    assign issue     = (state == ST_RUN) && (words_left != '0) && (fill < (AW+2)'(FIFO_DEPTH));
    assign accept    = issue && bus.HREADY;
    assign push      = outstanding && bus.HREADY;
    assign pix_fire  = bus.pix_valid && bus.pix_ready;
    assign pop       = pix_fire && (byte_idx == 2'd3);
    assign last_byte = (state == ST_DRAIN) && pop && !outstanding && (count == (AW+1)'(1));

    assign busy        = (state != ST_IDLE);
    assign bus.HADDR   = {addr_q, 2'b00};
    assign bus.HTRANS  = !issue ? TR_IDLE : (seq_q ? TR_SEQ : TR_NONSEQ);
    assign bus.HWRITE  = 1'b0;
    assign bus.HSIZE   = 3'b010;
    assign bus.pix_valid = (count != '0);
    assign head_word   = fifo_mem[rd_ptr];

    always_comb begin
        bus.pix_data = 8'h00;
        if (bus.pix_valid) begin
            case (byte_idx)
                2'd0:    bus.pix_data = head_word[7:0];
                2'd1:    bus.pix_data = head_word[15:8];
                2'd2:    bus.pix_data = head_word[23:16];
                default: bus.pix_data = head_word[31:24];
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) fifo_mem[wr_ptr] <= bus.HRDATA;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            words_left  <= '0;
            outstanding <= 1'b0;
            seq_q       <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            byte_idx    <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len_words == '0) begin
                            done <= 1'b1;
                        end else begin
                            state      <= ST_RUN;
                            addr_q     <= base_addr[31:2];
                            words_left <= len_words;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept && (words_left == LEN_W'(1))) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (last_byte) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (accept) begin
                addr_q     <= addr_q + 30'd1;
                words_left <= words_left - LEN_W'(1);
            end

            // Address/data pipeline advances only on HREADY; an IDLE slot breaks the SEQ burst.
            if (bus.HREADY) begin
                outstanding <= issue;
                seq_q       <= issue;
            end else if (!issue) begin
                seq_q <= 1'b0;
            end

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (pix_fire) byte_idx <= byte_idx + 2'd1;

            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
